// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - AES-128 inverse key schedule, emits round keys NR down to 0
module inv_key_schedule #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] last_key,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_round,
   output logic         busy,
   output logic         done
);

   localparam logic [3:0] NR_W = 4'(NR);

   // Forward AES S-box, entry 0 in the top byte
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   round_q, round_d;
   logic         valid_q, valid_d;
   logic         done_q, done_d;

   logic [31:0]  w0c, w1c, w2c, w3c;
   logic [31:0]  w0p, w1p, w2p, w3p;
   logic [31:0]  rot_w, sub_w;
   logic [127:0] prev_key;
   logic         accept;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   // Rcon for the forward step that produced round r; r=0 never reaches here
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Undo one forward expansion step: recover round r-1 key from round r key
   always_comb begin
      {w0c, w1c, w2c, w3c} = key_q;
      w3p      = w3c ^ w2c;
      w2p      = w2c ^ w1c;
      w1p      = w1c ^ w0c;
      rot_w    = {w3p[23:0], w3p[31:24]};
      sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
      w0p      = w0c ^ sub_w ^ {rcon(round_q), 24'h0};
      prev_key = {w0p, w1p, w2p, w3p};
   end

   assign accept = valid_q & rk_ready;

   // Next-state logic for the IDLE/EMIT walk
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = last_key;
               round_d = NR_W;
               valid_d = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (accept) begin
               if (round_q != 4'd0) begin
                  key_d   = prev_key;
                  round_d = round_q - 4'd1;
               end else begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= 128'h0;
         round_q <= 4'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign rk_valid = valid_q;
   assign rk_data  = key_q;
   assign rk_round = round_q;
   assign busy     = (state_q == EMIT);
   assign done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb/tb_inv_key_schedule.sv - directed and round-trip checks for inv_key_schedule
module tb_inv_key_schedule;

   localparam int NR = 10;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] last_key;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_round;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int unsigned  rnd;
      logic [127:0] key;
   } vec_t;

   vec_t         fips [11];
   logic [127:0] exp_k [0:10];

   inv_key_schedule #(.NR(NR)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .last_key (last_key),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_data  (rk_data),
      .rk_round (rk_round),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [2047:0] t;
      t = SBOX_TBL;
      return t[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input int r);
      logic [7:0] v;
      v = 8'h01;
      for (int i = 1; i < r; i++) v = v[7] ? ((v << 1) ^ 8'h1b) : (v << 1);
      return v;
   endfunction

   // Forward AES-128 expansion step producing round r from round r-1
   function automatic logic [127:0] fwd(input logic [127:0] k, input int r);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
      w0 = w0 ^ t ^ {rcon(r), 24'h0};
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // One full walk starting from exp_k[10], checking each accepted key against exp_k
   task automatic run_walk(input string tag, input bit rand_ready, input bit poke_start);
      int           cyc;
      int           exp_r;
      int           errs;
      bit           fin;
      bit           stall;
      logic [127:0] held_d;
      logic [3:0]   held_r;
      @(negedge clk);
      start    = 1'b1;
      last_key = exp_k[10];
      rk_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      exp_r = 10;
      errs  = 0;
      fin   = 1'b0;
      stall = 1'b0;
      held_d = '0;
      held_r = '0;
      while (!fin && cyc < 400) begin
         if (exp_r < 0) begin
            check({tag, "_done_pulse"}, 128'(done), 128'(1));
            check({tag, "_valid_after_done"}, 128'(rk_valid), 128'(0));
            if (!rand_ready) check({tag, "_start_to_done"}, 128'(cyc), 128'(NR + 2));
            start    = 1'b0;
            rk_ready = 1'b0;
            fin      = 1'b1;
         end else begin
            if (done || !rk_valid || !busy) errs++;
            if (stall && (rk_data !== held_d || rk_round !== held_r)) errs++;
            if (rk_round !== 4'(exp_r)) errs++;
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = poke_start && rk_valid && (rk_round == 4'd7 || rk_round == 4'd0);
            if (rk_ready) begin
               check($sformatf("%s_key_r%0d", tag, exp_r), rk_data, exp_k[exp_r]);
               exp_r--;
               stall = 1'b0;
            end else begin
               stall  = 1'b1;
               held_d = rk_data;
               held_r = rk_round;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start    = 1'b0;
      rk_ready = 1'b0;
      check({tag, "_finished_in_budget"}, 128'(fin), 128'(1));
      check({tag, "_glitches"}, 128'(errs), 128'(0));
      @(negedge clk);
      check({tag, "_idle_after"}, {125'h0, done, rk_valid, busy}, 128'h0);
   endtask

   initial begin
      int n;
      fips[0]  = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
      fips[1]  = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
      fips[2]  = '{2,  128'hf2c295f27a96b9435935807a7359f67f};
      fips[3]  = '{3,  128'h3d80477d4716fe3e1e237e446d7a883b};
      fips[4]  = '{4,  128'hef44a541a8525b7fb671253bdb0bad00};
      fips[5]  = '{5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
      fips[6]  = '{6,  128'h6d88a37a110b3efddbf98641ca0093fd};
      fips[7]  = '{7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
      fips[8]  = '{8,  128'head27321b58dbad2312bf5607f8d292f};
      fips[9]  = '{9,  128'hac7766f319fadc2128d12941575c006e};
      fips[10] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

      rst_n    = 1'b0;
      start    = 1'b0;
      last_key = '0;
      rk_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {123'h0, rk_valid, busy, done, 2'b00}, 128'h0);
      check("reset_data", rk_data, 128'h0);
      check("reset_round", 128'(rk_round), 128'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_no_start", {125'h0, rk_valid, busy, done}, 128'h0);

      for (int i = 0; i < 11; i++) exp_k[fips[i].rnd] = fips[i].key;

      run_walk("fips_full", 1'b0, 1'b0);
      run_walk("fips_bp", 1'b1, 1'b0);
      run_walk("fips_poke", 1'b0, 1'b1);
      run_walk("fips_bp_poke", 1'b1, 1'b1);

      // Reset asserted mid-walk at round 5
      @(negedge clk);
      start    = 1'b1;
      last_key = exp_k[10];
      rk_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(rk_valid && rk_round == 4'd5) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("mid_reset_reached_r5", 128'(rk_round), 128'(5));
      rst_n = 1'b0;
      #1;
      check("mid_reset_ctrl", {125'h0, rk_valid, busy, done}, 128'h0);
      check("mid_reset_data", rk_data, 128'h0);
      repeat (2) @(negedge clk);
      check("mid_reset_no_done", 128'(done), 128'h0);
      rk_ready = 1'b0;
      rst_n    = 1'b1;
      repeat (3) @(negedge clk);
      check("after_release_idle", {125'h0, rk_valid, busy, done}, 128'h0);
      run_walk("replay", 1'b0, 1'b0);

      // Round trip from random original keys through the forward expansion
      for (int t = 0; t < 3; t++) begin
         exp_k[0] = {$urandom, $urandom, $urandom, $urandom};
         for (int r = 1; r <= 10; r++) exp_k[r] = fwd(exp_k[r-1], r);
         run_walk($sformatf("rt%0d", t), t[0], 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
